julia_iter_engine: RTL and testbench
====================================

Name: julia_iter_engine

Overview:
- Sequential, synthesizable Julia-set engine; replaces the loop-in-always_comb floating-point fractal calculator.
- Scans a W x H frame in raster order in signed fixed point and performs one z <- z^2 + c step per clock.
- Emits one escape-count result per pixel over a valid/ready stream to the downstream colour-map/draw stage.
- Parametrised in data width, fraction bits, frame size, iteration limit and escape radius; adds start/busy/done control and backpressure.

Parameters:
- DW, 18, signed fixed-point width of c, step and z.
- FRAC, 13, fractional bits, Q(DW-FRAC).FRAC.
- IMG_W, 640, pixels per row.
- IMG_H, 480, rows per frame.
- MAX_ITER, 100, iteration limit (>= 1).
- ESC_R2, 25, integer squared escape radius; must be < 2^(2*(DW-FRAC-1)).
- IW, 8, width of iter_count; must hold MAX_ITER.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle frame request
- c_re  in  DW  real part of c, signed fixed point
- c_im  in  DW  imaginary part of c
- step  in  DW  pixel pitch in the complex plane, signed fixed point
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last pixel is accepted
- pix_valid  out  1  result available
- pix_ready  in  1  downstream accepts result
- x_draw  out  $clog2(IMG_W)  pixel column
- y_draw  out  $clog2(IMG_H)  pixel row
- iter_count  out  IW  escape iteration (0..MAX_ITER-1), or MAX_ITER if not escaped
- escaped  out  1  1 if the pixel escaped

Behaviour:
- Reset (async assert, sync release): state IDLE; busy, done, pix_valid, escaped = 0; x_draw, y_draw, iter_count = 0; internal z, n and coordinates = 0.
- States: IDLE, INIT, ITER, EMIT.
- IDLE:
  - start=1 latches c_re, c_im, step.
  - Sets x=0, y=0, busy=1, x_coord = -(IMG_W/2)*step, y_coord = -(IMG_H/2)*step; go to INIT.
  - Both products truncate to DW bits.
- start is ignored whenever busy=1. Latched c/step stay fixed for the whole frame.
- INIT (1 cycle): z_re <= x_coord, z_im <= y_coord, n <= 0; go to ITER.
- ITER (one iteration per cycle):
  - zr2 = z_re*z_re, zi2 = z_im*z_im, zri = z_re*z_im, all full 2*DW products.
  - z_re' = sat_DW(((zr2 - zi2) >>> FRAC) + c_re).
  - z_im' = sat_DW(((2*zri) >>> FRAC) + c_im).
  - Arithmetic shift; saturate to the DW signed range; no wrap.
  - mag = z_re'^2 + z_im'^2 in 2*DW+1 bits, compared against ESC_R2 << (2*FRAC). Strictly greater means escape.
  - Escape: iter_count <= n, escaped <= 1, go to EMIT.
  - No escape and n == MAX_ITER-1: iter_count <= MAX_ITER, escaped <= 0, go to EMIT.
  - Otherwise z <= z', n <= n+1, stay in ITER.
- EMIT:
  - pix_valid=1 with x_draw, y_draw, iter_count, escaped held stable until pix_valid && pix_ready.
  - On acceptance, advance x (x_coord += step). At x = IMG_W-1, wrap x to 0, x_coord to its row start, y += 1, y_coord += step.
  - If the accepted pixel was (IMG_W-1, IMG_H-1): pix_valid=0, busy=0, done=1 for exactly one cycle, go to IDLE.
  - Otherwise go to INIT, with pix_valid low the next cycle.
- Per-pixel latency: 1 (INIT) + k (ITER, k = n+1 <= MAX_ITER) cycles to pix_valid, plus stall cycles while pix_ready=0.
- pix_ready asserted before pix_valid has no effect. Outputs must not change while pix_valid=1 and pix_ready=0.
- Reset mid-frame aborts immediately to the reset values. No partial done.
- start in the same cycle as done is accepted (the engine is back in IDLE that cycle).

Test Plan:
- Reset values: assert rst_n=0 mid-ITER -> all outputs 0 asynchronously and state IDLE. A new start after release runs a full frame from (0,0).
- Non-escape: IMG_W=4, IMG_H=2, MAX_ITER=8, c=0, step=0 -> 8 pixels, all iter_count=8, escaped=0. Pixel spacing is 1+8 cycles plus 1 EMIT cycle with pix_ready=1; done pulses once after pixel (3,1).
- Immediate escape: c=0, step=3.0, ESC_R2=25, pixel (0,0) at z0=(-6,-3) -> z1 magnitude > 5, so iter_count=0, escaped=1. Pixel (2,1) at z0=(0,0) -> iter_count=MAX_ITER, escaped=0.
- Saturation: c_re = max positive, large step -> z' saturates rather than wrapping, and the pixel reports escaped=1, iter_count=0.
- Backpressure: hold pix_ready=0 for 5 cycles during EMIT -> pix_valid stays 1 with x_draw/y_draw/iter_count stable. Raster order is preserved and no pixel is lost or duplicated (count = IMG_W*IMG_H).
- Control: start pulsed while busy -> ignored, no restart and c unchanged. start in the done cycle -> a new frame begins, with busy=1 on the following cycle.

Source files
------------

// File: rtl/julia_iter_engine.sv
// Julia-set escape-time engine. It scans an IMG_W x IMG_H frame in raster
// order and performs one z <- z^2 + c step per clock in signed
// Q(DW-FRAC).FRAC fixed point. It emits one escape count per pixel over a
// valid/ready stream.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              one-cycle frame request (ignored while busy)
//   c_re, c_im, step   Julia constant and pixel pitch, signed fixed point
//   busy               frame in progress
//   done               one-cycle pulse after the last pixel is accepted
//   pix_valid          result available
//   pix_ready          downstream accepts the result
//   x_draw, y_draw     pixel column / row of the result
//   iter_count         escape iteration, or MAX_ITER if not escaped
//   escaped            1 if the pixel escaped
//
// IMG_W and IMG_H must be >= 2 so that the coordinate ports are non-empty.
module julia_iter_engine #(
   parameter int unsigned DW       = 18,
   parameter int unsigned FRAC     = 13,
   parameter int unsigned IMG_W    = 640,
   parameter int unsigned IMG_H    = 480,
   parameter int unsigned MAX_ITER = 100,
   parameter int unsigned ESC_R2   = 25,
   parameter int unsigned IW       = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [DW-1:0]              c_re,
   input  logic [DW-1:0]              c_im,
   input  logic [DW-1:0]              step,
   output logic                       busy,
   output logic                       done,
   output logic                       pix_valid,
   input  logic                       pix_ready,
   output logic [$clog2(IMG_W)-1:0]   x_draw,
   output logic [$clog2(IMG_H)-1:0]   y_draw,
   output logic [IW-1:0]              iter_count,
   output logic                       escaped
);

   localparam int unsigned XW = $clog2(IMG_W);
   localparam int unsigned YW = $clog2(IMG_H);
   localparam int unsigned OW = 2 * DW;       // start-offset product width
   localparam int unsigned PW = 2 * DW + 2;   // headroom for 2*z_re*z_im
   localparam int unsigned MW = 2 * DW + 1;   // |z|^2 width

   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
   localparam logic [IW-1:0] N_LAST = IW'(MAX_ITER - 1);
   localparam logic [IW-1:0] N_MAX  = IW'(MAX_ITER);

   localparam logic signed [PW-1:0] SAT_HI = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [PW-1:0] SAT_LO = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};
   localparam logic signed [MW-1:0] ESC_T  = MW'(ESC_R2) << (2 * FRAC);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      ITER = 2'd2,
      EMIT = 2'd3
   } state_t;

   state_t state;

   logic signed [DW-1:0] c_re_q;
   logic signed [DW-1:0] c_im_q;
   logic signed [DW-1:0] step_q;
   logic signed [DW-1:0] x_start;
   logic signed [DW-1:0] x_coord;
   logic signed [DW-1:0] y_coord;
   logic signed [DW-1:0] z_re;
   logic signed [DW-1:0] z_im;
   logic [IW-1:0]        n;

   logic signed [OW-1:0] x_off_c;
   logic signed [OW-1:0] y_off_c;
   logic signed [DW-1:0] x_start_c;
   logic signed [DW-1:0] y_start_c;

   logic signed [PW-1:0] zr2_c;
   logic signed [PW-1:0] zi2_c;
   logic signed [PW-1:0] zri_c;
   logic signed [PW-1:0] re_sum_c;
   logic signed [PW-1:0] im_sum_c;
   logic signed [DW-1:0] zr_next_c;
   logic signed [DW-1:0] zi_next_c;
   logic signed [MW-1:0] sq_r_c;
   logic signed [MW-1:0] sq_i_c;
   logic signed [MW-1:0] mag_c;
   logic                 esc_c;

   // Clamp a wide intermediate into the DW signed range instead of wrapping.
   function automatic logic signed [DW-1:0] sat_dw(input logic signed [PW-1:0] v);
      if (v > SAT_HI) begin
         return DW'(SAT_HI);
      end else if (v < SAT_LO) begin
         return DW'(SAT_LO);
      end else begin
         return DW'(v);
      end
   endfunction

   // Top-left corner of the frame: -(IMG_W/2)*step, -(IMG_H/2)*step, truncated to DW.
   always_comb begin
      x_off_c   = OW'($signed(step)) * $signed(OW'(IMG_W / 2));
      y_off_c   = OW'($signed(step)) * $signed(OW'(IMG_H / 2));
      x_start_c = DW'(-x_off_c);
      y_start_c = DW'(-y_off_c);
   end

   // One Julia step plus the escape test on the new z.
   always_comb begin
      zr2_c     = PW'(z_re) * PW'(z_re);
      zi2_c     = PW'(z_im) * PW'(z_im);
      zri_c     = PW'(z_re) * PW'(z_im);
      re_sum_c  = ((zr2_c - zi2_c) >>> FRAC) + PW'(c_re_q);
      im_sum_c  = ((zri_c <<< 1) >>> FRAC) + PW'(c_im_q);
      zr_next_c = sat_dw(re_sum_c);
      zi_next_c = sat_dw(im_sum_c);
      sq_r_c    = MW'(zr_next_c) * MW'(zr_next_c);
      sq_i_c    = MW'(zi_next_c) * MW'(zi_next_c);
      mag_c     = sq_r_c + sq_i_c;
      esc_c     = (mag_c > ESC_T);
   end

   // Control FSM, raster scan and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         pix_valid  <= 1'b0;
         escaped    <= 1'b0;
         x_draw     <= '0;
         y_draw     <= '0;
         iter_count <= '0;
         c_re_q     <= '0;
         c_im_q     <= '0;
         step_q     <= '0;
         x_start    <= '0;
         x_coord    <= '0;
         y_coord    <= '0;
         z_re       <= '0;
         z_im       <= '0;
         n          <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  c_re_q  <= $signed(c_re);
                  c_im_q  <= $signed(c_im);
                  step_q  <= $signed(step);
                  x_start <= x_start_c;
                  x_coord <= x_start_c;
                  y_coord <= y_start_c;
                  x_draw  <= '0;
                  y_draw  <= '0;
                  busy    <= 1'b1;
                  state   <= INIT;
               end
            end

            INIT: begin
               z_re  <= x_coord;
               z_im  <= y_coord;
               n     <= '0;
               state <= ITER;
            end

            ITER: begin
               if (esc_c) begin
                  iter_count <= n;
                  escaped    <= 1'b1;
                  pix_valid  <= 1'b1;
                  state      <= EMIT;
               end else if (n == N_LAST) begin
                  iter_count <= N_MAX;
                  escaped    <= 1'b0;
                  pix_valid  <= 1'b1;
                  state      <= EMIT;
               end else begin
                  z_re <= zr_next_c;
                  z_im <= zi_next_c;
                  n    <= n + IW'(1);
               end
            end

            EMIT: begin
               // Result registers stay frozen until the handshake completes.
               if (pix_ready) begin
                  pix_valid <= 1'b0;
                  if (x_draw == X_LAST) begin
                     x_draw  <= '0;
                     x_coord <= x_start;
                     if (y_draw == Y_LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                     end else begin
                        y_draw  <= y_draw + YW'(1);
                        y_coord <= y_coord + step_q;
                        state   <= INIT;
                     end
                  end else begin
                     x_draw  <= x_draw + XW'(1);
                     x_coord <= x_coord + step_q;
                     state   <= INIT;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_julia_iter_engine.sv
// Self-checking bench for julia_iter_engine on a small 4x2 frame. Expected
// pixels come from a plain-integer model of the Julia iteration.
module tb_julia_iter_engine;

   localparam int DW  = 18;
   localparam int FR  = 13;
   localparam int W   = 4;
   localparam int H   = 2;
   localparam int MI  = 8;
   localparam int ER2 = 25;
   localparam int IW  = 8;
   localparam int XW  = $clog2(W);
   localparam int YW  = $clog2(H);
   localparam longint ONE = 64'sd1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic [DW-1:0] c_re = '0;
   logic [DW-1:0] c_im = '0;
   logic [DW-1:0] step = '0;
   logic          busy;
   logic          done;
   logic          pix_valid;
   logic          pix_ready = 1'b0;
   logic [XW-1:0] x_draw;
   logic [YW-1:0] y_draw;
   logic [IW-1:0] iter_count;
   logic          escaped;

   int n_checks = 0;
   int n_pass   = 0;

   longint obs_it [W][H];
   longint obs_es [W][H];

   julia_iter_engine #(
      .DW(DW), .FRAC(FR), .IMG_W(W), .IMG_H(H),
      .MAX_ITER(MI), .ESC_R2(ER2), .IW(IW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .c_re(c_re), .c_im(c_im), .step(step),
      .busy(busy), .done(done),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .x_draw(x_draw), .y_draw(y_draw),
      .iter_count(iter_count), .escaped(escaped)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Two's-complement wrap of an integer into DW bits.
   function automatic longint wrap_dw(input longint v);
      longint m;
      m = v & ((ONE <<< DW) - 1);
      if (m >= (ONE <<< (DW - 1))) m = m - (ONE <<< DW);
      return m;
   endfunction

   function automatic longint sat_dw(input longint v);
      longint hi, lo;
      hi = (ONE <<< (DW - 1)) - 1;
      lo = -(ONE <<< (DW - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // Escape-time of one starting point under z <- z^2 + c.
   task automatic ref_pixel(input longint cr, input longint ci, input longint zr0,
                            input longint zi0, output longint it, output longint es);
      longint zr, zi, nr, ni, lim;
      zr  = zr0;
      zi  = zi0;
      lim = longint'(ER2) <<< (2 * FR);
      it  = MI;
      es  = 0;
      for (int k = 0; k < MI; k++) begin
         nr = sat_dw(((zr * zr - zi * zi) >>> FR) + cr);
         ni = sat_dw(((2 * zr * zi) >>> FR) + ci);
         if (nr * nr + ni * ni > lim) begin
            it = k;
            es = 1;
            return;
         end
         zr = nr;
         zi = ni;
      end
   endtask

   function automatic longint pack(input longint x, input longint y, input longint e,
                                   input longint it);
      return (x <<< 24) | (y <<< 16) | (e <<< 8) | it;
   endfunction

   // mode 0: always ready, 1: random stalls, 2: five-cycle stall per pixel.
   task automatic run_frame(input longint cr, input longint ci, input longint st,
                            input int mode, input bit chain_next, input bit skip_start,
                            input bit poke, input bit timing);
      longint exp_q[$];
      longint x0, y0, it, es, obs, held;
      int     got, cycles, last_acc, stall_left;
      bit     done_seen, stalled;

      x0 = wrap_dw(-longint'(W / 2) * st);
      y0 = wrap_dw(-longint'(H / 2) * st);
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            ref_pixel(cr, ci, wrap_dw(x0 + x * st), wrap_dw(y0 + y * st), it, es);
            exp_q.push_back(pack(x, y, es, it));
         end
      end

      if (!skip_start) begin
         @(negedge clk);
         c_re  = DW'(cr);
         c_im  = DW'(ci);
         step  = DW'(st);
         start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);

      cycles = 0; got = 0; last_acc = 0; stall_left = 0;
      done_seen = 0; stalled = 0; held = 0;
      while (!done_seen && cycles < 1000) begin
         @(negedge clk);
         cycles++;
         if (poke && cycles == 3) begin
            start = 1'b1;
            c_re  = DW'(cr + 777);
            step  = DW'(st + 99);
         end else if (poke && cycles == 4) begin
            start = 1'b0;
            c_re  = DW'(cr);
            step  = DW'(st);
         end
         if (done) begin
            done_seen = 1;
            check("done_valid_low", pix_valid, 0);
            check("done_busy_low", busy, 0);
            pix_ready = 1'b0;
            if (chain_next) start = 1'b1;
         end else if (pix_valid) begin
            obs = pack(x_draw, y_draw, escaped, iter_count);
            if (stalled) check("stall_hold", obs, held);
            else stall_left = (mode == 2) ? 5 : (mode == 1) ? int'($urandom_range(0, 3)) : 0;
            if (stall_left > 0) begin
               stall_left--;
               stalled   = 1;
               held      = obs;
               pix_ready = 1'b0;
            end else begin
               stalled   = 0;
               pix_ready = 1'b1;
               if (timing) begin
                  if (got == 0) check("first_latency", cycles, MI + 1);
                  else check("pixel_spacing", cycles - last_acc, MI + 2);
               end
               last_acc = cycles;
               if (got < exp_q.size()) check("pixel", obs, exp_q[got]);
               else check("extra_pixel", got, exp_q.size());
               obs_it[x_draw][y_draw] = iter_count;
               obs_es[x_draw][y_draw] = escaped;
               got++;
            end
         end else begin
            if (stalled) check("valid_held", pix_valid, 1);
            stalled   = 0;
            pix_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end
      if (!done_seen) check("frame_timeout", 0, 1);
      check("pixel_count", got, W * H);
      if (!chain_next) begin
         @(negedge clk);
         check("done_one_cycle", done, 0);
         check("idle_busy", busy, 0);
      end
   endtask

   function automatic longint rnd_c();
      return longint'($urandom_range(0, 16384)) - 8192;
   endfunction

   function automatic longint rnd_step();
      return longint'($urandom_range(0, 6144)) - 2048;
   endfunction

   initial begin
      longint cr, ci, st;

      // Power-on reset.
      #3 rst_n = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", pix_valid, 0);
      check("rst_xy_iter", pack(x_draw, y_draw, escaped, iter_count), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // c = 0, step = 0: nothing escapes, fixed cadence.
      run_frame(0, 0, 0, 0, 0, 0, 0, 1);
      check("nonesc_iter", obs_it[3][1], MI);
      check("nonesc_esc", obs_es[3][1], 0);

      // step = 3.0: corner escapes at once, centre never does.
      run_frame(0, 0, 3 <<< FR, 0, 0, 0, 0, 0);
      check("imm_esc_iter", obs_it[0][0], 0);
      check("imm_esc_flag", obs_es[0][0], 1);
      check("centre_iter", obs_it[2][1], MI);
      check("centre_flag", obs_es[2][1], 0);

      // Maximum c_re with a large step must saturate, not wrap.
      run_frame((ONE <<< (DW - 1)) - 1, 0, 4 <<< FR, 0, 0, 0, 0, 0);
      check("sat_iter", obs_it[0][0], 0);
      check("sat_flag", obs_es[0][0], 1);
      check("sat_centre_flag", obs_es[2][1], 1);

      // Five-cycle backpressure plus a start pulse while busy.
      cr = rnd_c(); ci = rnd_c(); st = rnd_step();
      run_frame(cr, ci, st, 2, 0, 0, 1, 0);

      // start in the done cycle chains straight into a new frame.
      cr = rnd_c(); ci = rnd_c(); st = rnd_step();
      run_frame(cr, ci, st, 1, 1, 0, 0, 0);
      run_frame(cr, ci, st, 1, 0, 1, 0, 0);

      // Random frames with random backpressure.
      for (int f = 0; f < 5; f++) begin
         run_frame(rnd_c(), rnd_c(), rnd_step(), 1, 0, 0, 0, 0);
      end

      // Reset in the middle of ITER for the second pixel.
      @(negedge clk);
      c_re = '0; c_im = '0; step = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      pix_ready = 1'b1;
      repeat (12) @(negedge clk);
      check("mid_busy", busy, 1);
      check("mid_x", x_draw, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_valid", pix_valid, 0);
      check("arst_done", done, 0);
      check("arst_xy_iter", pack(x_draw, y_draw, escaped, iter_count), 0);
      @(negedge clk);
      pix_ready = 1'b0;
      rst_n = 1'b1;
      run_frame(0, 0, 0, 0, 0, 0, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
